// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW unit over a word-wide memory; define LSU_BOUNDS_CHECK_EN to flag addresses beyond DEPTH
module load_store_unit #(
  parameter int DEPTH = 1024,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;
  state_t state, state_n;
  logic [31:0] addr_q, wbuf, ld_val, merged;
  logic [2:0]  f3_q;
  logic [15:0] lane_h;
  logic [7:0]  lane_b;
  logic        err, oob, sgn;
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  assign oob = BOUNDS && ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign err = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]) ||
               (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) || oob;
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign mem_read   = !reset && (state == RD || state == RMW_RD);
  assign mem_write  = !reset && state == WR;
  assign mem_addr   = AW'(addr_q[31:2]);
  assign mem_wdata  = wbuf;
  assign lane_b     = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h     = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign sgn        = !f3_q[2];
  // Lane extraction with sign/zero extension for loads
  always_comb begin
    ld_val = f3_q[1:0] == 2'b10 ? mem_rdata :
             f3_q[0] ? {{16{sgn & lane_h[15]}}, lane_h} : {{24{sgn & lane_b[7]}}, lane_b};
  end
  // Splice the buffered store byte/halfword into the word read back from memory
  always_comb begin
    merged = mem_rdata;
    if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wbuf[15:0];
    else merged[{addr_q[1:0], 3'b000} +: 8] = wbuf[7:0];
  end
  // Next-state decode; errors skip memory entirely, sub-word stores take the read-modify-write path
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !req_valid ? IDLE : err ? RESP : !req_we ? RD : req_funct3[1:0] == 2'b10 ? WR : RMW_RD;
      RD:      state_n = RESP;
      RMW_RD:  state_n = WR;
      WR:      state_n = RESP;
      RESP:    state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // State, request latches, write buffer and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      f3_q       <= '0;
      wbuf       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        addr_q     <= req_addr;
        f3_q       <= req_funct3;
        wbuf       <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= err;
      end
      if (state == RD) resp_rdata <= ld_val;
      if (state == RMW_RD) wbuf <= merged;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed transactions checked against a byte-level reference memory model
module tb_load_store_unit;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_we = 0, resp_ready = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:2047];
  logic [31:0] ref_mem [0:2047];
  int checks = 0, errors = 0, rd_cnt = 0, wr_cnt = 0;
  bit exp_active = 0;
  logic exp_err, last_err;
  logic [31:0] exp_rdata, exp_maddr, exp_wdata, last_wdata, last_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(1024), .AW(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[10:0]];

  // Attached memory: writes land on the clock edge, strobe cycles are counted there
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[10:0]] <= mem_wdata;
      wr_cnt++;
    end
    if (mem_read) rd_cnt++;
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  // Compare process: every cycle on the falling edge
  always @(negedge clk) begin
    chk("strobe_exclusive", {31'b0, mem_read & mem_write}, 0);
    if (exp_active && !reset) begin
      if (resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
        last_rdata = resp_rdata;
        last_err = resp_err;
      end
      if (mem_read || mem_write) chk("mem_addr", mem_addr, exp_maddr);
      if (mem_write) begin
        chk("mem_wdata", mem_wdata, exp_wdata);
        last_wdata = mem_wdata;
      end
    end
  end

  // Reference behaviour: byte-lane arithmetic on the reference memory
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rdata, output int lat, output int nrd,
                       output int nwr, output logic [31:0] nword);
    int size, sh;
    logic [31:0] word, mask;
    size = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    sh = 8 * int'(a[1:0]);
    word = ref_mem[a[12:2]];
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
    err = f3 == 3 || f3 == 6 || f3 == 7 || (we && f3[2]) || (size == 2 && a[0]) || (size == 4 && a[1:0] != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    if (a[31:2] >= 1024) err = 1;
`endif
    rdata = 0; nword = word; nrd = 0; nwr = 0; lat = 1;
    if (!err) begin
      if (!we) begin
        rdata = (word >> sh) & mask;
        if (!f3[2] && size < 4 && rdata[8 * size - 1]) rdata = rdata | ~mask;
        lat = 2; nrd = 1;
      end else begin
        nword = (word & ~(mask << sh)) | ((wd & mask) << sh);
        nwr = 1;
        nrd = (size < 4) ? 1 : 0;
        lat = (size < 4) ? 3 : 2;
      end
    end
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic e;
    logic [31:0] r, nw;
    int lat, nrd, nwr, n;
    model(we, f3, a, wd, e, r, lat, nrd, nwr, nw);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 1);
    exp_err = e; exp_rdata = r; exp_maddr = {2'b00, a[31:2]}; exp_wdata = nw; exp_active = 1;
    rd_cnt = 0; wr_cnt = 0;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 10);
    chk("latency", n, lat);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1;
      @(negedge clk);
      chk("hold_req_ready", {31'b0, req_ready}, 0);
      chk("hold_resp_valid", {31'b0, resp_valid}, 1);
    end
    req_valid = 0;
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    exp_active = 0;
    ref_mem[a[12:2]] = nw;
    @(negedge clk);
    chk("mem_read_cycles", rd_cnt, nrd);
    chk("mem_write_cycles", wr_cnt, nwr);
    chk("idle_after_resp", {31'b0, req_ready}, 1);
    chk("resp_valid_drop", {31'b0, resp_valid}, 0);
    chk("mem_word", mem[a[12:2]], ref_mem[a[12:2]]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 0;
      ref_mem[i] = 0;
    end
    mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
    mem[5] = 32'h11223344; ref_mem[5] = 32'h11223344;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_resp_err", {31'b0, resp_err}, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 0);
    xact(0, 3'b000, 32'h12, 0, 0);
    chk("lit_lb", last_rdata, 32'hFFFFFF99);
    xact(0, 3'b100, 32'h12, 0, 0);
    chk("lit_lbu", last_rdata, 32'h00000099);
    xact(0, 3'b101, 32'h10, 0, 0);
    chk("lit_lhu", last_rdata, 32'h0000AABB);
    xact(0, 3'b001, 32'h12, 0, 0);
    chk("lit_lh", last_rdata, 32'hFFFF8899);
    xact(0, 3'b010, 32'h10, 0, 0);
    xact(1, 3'b001, 32'h16, 32'h1234CAFE, 0);
    chk("lit_sh_wdata", last_wdata, 32'hCAFE3344);
    chk("lit_sh_err", {31'b0, last_err}, 0);
    xact(1, 3'b010, 32'h14, 32'hDEADBEEF, 0);
    chk("lit_sw_mem", mem[5], 32'hDEADBEEF);
    xact(1, 3'b000, 32'h15, 32'h000000A5, 0);
    chk("lit_sb_mem", mem[5], 32'hDEADA5EF);
    xact(0, 3'b010, 32'h13, 0, 0);
    chk("lit_lw_mis_err", {31'b0, last_err}, 1);
    xact(1, 3'b001, 32'h11, 32'h5555, 0);
    chk("lit_sh_mis_err", {31'b0, last_err}, 1);
    xact(0, 3'b011, 32'h10, 0, 0);
    chk("lit_f3_011_rdata", last_rdata, 0);
    xact(1, 3'b100, 32'h10, 32'h1, 0);
    xact(0, 3'b101, 32'h13, 0, 0);
    xact(0, 3'b110, 32'h10, 0, 0);
    xact(0, 3'b000, 32'h12, 0, 3);
    chk("lit_hold_lb", last_rdata, 32'hFFFFFF99);
    xact(0, 3'b010, 32'h1000, 0, 0);
`ifdef LSU_BOUNDS_CHECK_EN
    chk("lit_oob_err", {31'b0, last_err}, 1);
`else
    chk("lit_oob_err", {31'b0, last_err}, 0);
`endif
    @(negedge clk);
    exp_active = 0;
    wr_cnt = 0;
    req_valid = 1; req_we = 1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("wr_state_strobe", {31'b0, mem_write}, 1);
    reset = 1;
    #1 chk("write_gated_by_reset", {31'b0, mem_write}, 0);
    @(posedge clk);
    @(negedge clk) reset = 0;
    @(negedge clk);
    chk("abort_req_ready", {31'b0, req_ready}, 1);
    chk("abort_resp_valid", {31'b0, resp_valid}, 0);
    chk("abort_wr_cnt", wr_cnt, 0);
    chk("abort_mem_unchanged", mem[4], 32'h8899AABB);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and data_memory.
- Accepts one load or store request per transaction over a valid/ready handshake and decodes RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Drives the word-addressed, word-wide data memory port. Byte and halfword stores are done as read-modify-write because the memory only writes full words.
- Returns a registered, sign- or zero-extended load result or an error flag over a second valid/ready handshake.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached data memory.
- AW, 32, width of the memory address port.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 access size and sign.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  misaligned access, illegal funct3, or out of range (optional feature).
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  AW  word address = req_addr[31:2].
- mem_wdata  output  32  full word to write.
- mem_rdata  input  32  combinational read data from memory.

Behaviour:
- State machine: IDLE, RD, RMW_RD, WR, RESP.
- Handshake accepts on req_valid & req_ready. req_ready = 1 only in IDLE. Address, funct3, we and wdata are latched on accept.

Decode at accept:
- Error if any of the following:
  - funct3 is in {011, 110, 111}.
  - Store with funct3[2] = 1.
  - Halfword with addr[0] ≠ 0.
  - Word with addr[1:0] ≠ 0.
- Error: go to RESP with resp_err = 1 and resp_rdata = 0. No memory strobe is asserted.
- Load: go to RD.
- SW: go to WR, with mem_wdata = req_wdata.
- SB/SH: go to RMW_RD.

States:
- RD:
  - mem_read = 1.
  - Extract the lane from mem_rdata, little-endian: byte lane addr[1:0], halfword lane addr[1].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Register the result into resp_rdata, resp_err = 0, then go to RESP.
- RMW_RD:
  - mem_read = 1.
  - Merge the store byte or halfword into mem_rdata at its lane and register it as the write word, then go to WR.
- WR:
  - mem_write = 1 for exactly one cycle, then go to RESP with resp_rdata = 0 and resp_err = 0.
- RESP:
  - resp_valid = 1.
  - resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready go to IDLE. No new request is accepted in that same cycle.

Strobes:
- mem_read and mem_write are decoded from state and gated with !reset, so they are never both high.
- mem_addr and mem_wdata hold the latched values outside RD/RMW_RD/WR.

Latency, counted as cycles from the accept edge to resp_valid = 1:
- Error: 1.
- Load or SW: 2.
- SB/SH: 3.
- Each transaction uses exactly one memory access cycle, or two for RMW.

Reset:
- State goes to IDLE; resp_valid = 0, resp_err = 0, resp_rdata = 0, write buffer = 0.
- req_ready = 1 the cycle after reset deasserts.
- Reset in any state, including WR, aborts the transaction. No mem_write occurs during the reset cycle and memory is unchanged.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- Defined: a request with req_addr[31:2] ≥ DEPTH is an error: go to RESP with resp_err = 1 and no memory access.
- Not defined: no range check. mem_addr = req_addr[31:2] zero-extended to AW and passed through unchanged; the attached memory's address decoding decides behaviour.

Test Plan:
- Word 4 preloaded with 0x8899AABB. LB at 0x12 → resp_rdata 0xFFFFFF99, resp_valid 2 cycles after accept, one mem_read cycle. LBU at 0x12 → 0x00000099. LHU at 0x10 → 0x0000AABB.
- Word 5 = 0x11223344. SH at 0x16 with wdata 0x1234CAFE → one mem_read cycle, then one mem_write cycle with mem_wdata 0xCAFE3344, resp_valid at cycle 3, resp_err 0. SW at 0x14 with 0xDEADBEEF → single mem_write, resp at cycle 2.
- LW at 0x13, SH at 0x11, and load funct3 011 → resp_err 1 and resp_rdata 0 at cycle 1, with mem_read and mem_write low throughout.
- Load completes with resp_ready held low for 3 cycles → resp_valid stays 1, resp_rdata is stable, req_ready is 0, and req_valid pulses are not accepted. After resp_ready: IDLE the next cycle.
- Reset asserted while in WR during an SB → mem_write stays 0 and memory is unchanged. After reset deasserts, req_ready = 1 and resp_valid = 0.
- DEPTH = 1024, LW at 0x1000:
  - With LSU_BOUNDS_CHECK_EN: resp_err 1, no strobes.
  - Without it: mem_addr = 0x400, mem_read asserted, resp_err 0.
